// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the nv_ram write-first RAM with clear engine.
package nv_ram_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } clr_state_e;

    // Smallest r such that 2**r >= n; constant-evaluated for parameter defaults.
    function automatic int unsigned nv_ram_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nv_ram_clr_fsm.sv
// Clear engine: walks every entry once, writing the init value, restartable by clr_req.
module nv_ram_clr_fsm
    import nv_ram_pkg::*;
#(
    parameter int unsigned DEPTH      = 19,
    parameter int unsigned AW         = nv_ram_clog2(DEPTH),
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic [AW-1:0] clr_cnt
);

    localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);
    localparam clr_state_e    RstState = CLR_ON_RST ? StClear : StIdle;

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RstState;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                // A new request wins over completion so a late restart is never lost.
                if (clr_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clr_busy = (state_q == StClear);
        clr_cnt  = cnt_q;
    end

    cnt_in_range_a: assert property (@(posedge clk) disable iff (rst)
        clr_busy |-> (32'(clr_cnt) < DEPTH));

endmodule

// File: rtl/nv_ram_rwsthp_gen.sv
// Write-first RAM with registered read address, output register with bypass and clear engine.
module nv_ram_rwsthp_gen
    import nv_ram_pkg::*;
#(
    parameter int unsigned      WIDTH      = 4,
    parameter int unsigned      DEPTH      = 19,
    parameter int unsigned      AW         = nv_ram_clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    parameter bit               CLR_ON_RST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic             byp_sel,
    input  logic [WIDTH-1:0] dbyp,
    input  logic             clr_req,
    output logic             clr_busy,
    input  logic [31:0]      pwrbus_ram_pd
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    clr_cnt;
    logic [AW-1:0]    ra_q;
    logic             s1_vld_q;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             wr_ok;
    logic [WIDTH-1:0] rd_data;

    // Power control has no functional effect on this model.
    logic unused_pwr;
    assign unused_pwr = ^pwrbus_ram_pd;

    nv_ram_clr_fsm #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_cnt  (clr_cnt)
    );

    assign wr_ok = we && !clr_busy && (32'(wa) < DEPTH);

    // Array is deliberately not reset; the clear engine defines its contents.
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem_q[clr_cnt] <= INIT_VAL;
        end else if (wr_ok) begin
            mem_q[wa] <= di;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q     <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            if (re) begin
                ra_q <= ra;
            end
            s1_vld_q <= re & ~clr_busy;
        end
    end

    // Array is read one cycle after the address is captured, so a same-edge write is visible.
    always_comb begin
        rd_data = '0;
        if (32'(ra_q) < DEPTH) begin
            rd_data = mem_q[ra_q];
        end
    end

    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        if (ore) begin
            dout_d     = byp_sel ? dbyp : rd_data;
            dout_vld_d = s1_vld_q | byp_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;

endmodule

// File: doc/nv_ram_rwsthp_gen.md
NV_RAM_RWSTHP_GEN -- requirements
Module: nv_ram_rwsthp_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 19: number of entries (2..1024).
REQ-003 SHALL have parameter AW, default ceil(log2(DEPTH)): address width.
REQ-004 SHALL have parameter INIT_VAL, default 0 (WIDTH bits): value written to every entry by the clear engine.
REQ-005 SHALL have parameter CLR_ON_RST, default 1: when 1, the clear engine runs automatically after reset.
REQ-006 SHALL have port clk  input  1: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-008 SHALL have port ra  input  AW: read address.
REQ-009 SHALL have port re  input  1: read enable; captures ra.
REQ-010 SHALL have port ore  input  1: output register enable.
REQ-011 SHALL have port dout  output  WIDTH: registered read data.
REQ-012 SHALL have port dout_vld  output  1: dout holds data from an accepted read or bypass.
REQ-013 SHALL have port wa  input  AW: write address.
REQ-014 SHALL have port we  input  1: write enable.
REQ-015 SHALL have port di  input  WIDTH: write data.
REQ-016 SHALL have port byp_sel  input  1: select dbyp instead of array data into the output register.
REQ-017 SHALL have port dbyp  input  WIDTH: bypass data.
REQ-018 SHALL have port clr_req  input  1: one-cycle pulse that starts or restarts a full clear.
REQ-019 SHALL have port clr_busy  output  1: clear engine active.
REQ-020 SHALL have port pwrbus_ram_pd  input  32: power control; functionally ignored.

Function
REQ-021 SHALL write di to entry wa on a clock edge where we=1, clr_busy=0 and wa<DEPTH; all other writes are dropped.
REQ-022 SHALL register ra into ra_d on an edge where re=1, and hold ra_d otherwise.
REQ-023 SHALL register s1_vld <= re & ~clr_busy on every edge.
REQ-024 SHALL form array data as entry ra_d, or zero when ra_d>=DEPTH.
REQ-025 SHALL load dout <= (byp_sel ? dbyp : array data) and dout_vld <= s1_vld | byp_sel on an edge where ore=1; both hold while ore=0.
REQ-026 SHALL give a read latency of 2 edges (re edge, ore edge) for a read issued with ore held at 1.
REQ-027 SHALL be write-first: a write to address X on the same edge as re captures ra=X returns the new data.
REQ-028 SHALL implement clear FSM states IDLE and CLEAR with counter clr_cnt (AW bits).
REQ-029 In IDLE, the FSM SHALL go to CLEAR with clr_cnt=0 on clr_req=1.
REQ-030 In CLEAR, the FSM SHALL write INIT_VAL to entry clr_cnt each edge and increment clr_cnt.
REQ-031 In CLEAR, the FSM SHALL return to IDLE after writing entry DEPTH-1, for exactly DEPTH busy cycles.
REQ-032 A clr_req=1 during CLEAR SHALL restart the clear with clr_cnt=0.
REQ-033 clr_busy SHALL equal (state==CLEAR).
REQ-034 During CLEAR, user writes SHALL be dropped and reads SHALL give s1_vld=0; bypass SHALL still function.

Reset
REQ-035 On rst=1, ra_d, dout, dout_vld, s1_vld and clr_cnt SHALL be 0 asynchronously.
REQ-036 On rst=1, state SHALL be CLEAR if CLR_ON_RST=1, else IDLE.
REQ-037 The array SHALL NOT be reset; contents after reset are defined only by the clear engine.
REQ-038 A rst assertion mid-clear SHALL abort the clear and apply REQ-035/036.

Structure
REQ-039 Package nv_ram_pkg SHALL hold the clear-state enum (IDLE, CLEAR) and the ceil-log2 function.
REQ-040 The clear FSM and counter SHALL be sub-module nv_ram_clr_fsm; array, read pipe and bypass mux stay in the top.

Verification
REQ-041 Test: with WIDTH=4, DEPTH=19, release rst -> clr_busy high for exactly 19 cycles; afterwards reading all 19 entries returns 0 with dout_vld=1.
REQ-042 Test: write 0xA to entry 5, then re with ra=5 and ore=1 -> dout=0xA and dout_vld=1 two edges after re.
REQ-043 Test: on one edge, we with wa=7 and di=0x3 plus re with ra=7 -> dout=0x3 (write-first).
REQ-044 Test: set byp_sel=1 with dbyp=0xC and ore=1 during CLEAR -> dout=0xC and dout_vld=1; a write to entry 2 during CLEAR is dropped and entry 2 reads INIT_VAL.
REQ-045 Test: write with wa=20, then read with ra=20 -> no array change and dout=0.
REQ-046 Test: pulse clr_req at clr_cnt=10 -> clr_cnt restarts at 0 and clr_busy stays high for 19 more cycles.
